// File: rtl/note_track_scroller_pkg.sv
// Shared definitions for the note track scroller.
// Holds the lane/x/y field widths, the default geometry of the note
// track, and the lane-to-x mapping used both when a note is placed and
// when a player strike is matched against a slot's lane.
package note_track_scroller_pkg;

  localparam int LANE_W = 3;
  localparam int X_W    = 11;
  localparam int Y_W    = 10;

  localparam int DEF_LANES      = 5;
  localparam int DEF_LANE_X0    = 100;
  localparam int DEF_LANE_PITCH = 80;
  localparam int DEF_TOP_Y      = 0;
  localparam int DEF_BOTTOM_Y   = 700;
  localparam int DEF_HIT_LO     = 560;
  localparam int DEF_HIT_HI     = 640;

  // Out-of-range lanes are folded onto the last lane so a bad request
  // still lands somewhere visible instead of off the right edge.
  function automatic logic [X_W-1:0] lane_to_x(
    input logic [LANE_W-1:0] lane,
    input int                lanes,
    input int                x0,
    input int                pitch
  );
    logic [LANE_W-1:0] l;
    l = (int'(lane) >= lanes) ? LANE_W'(lanes - 1) : lane;
    return X_W'(x0) + X_W'(l) * X_W'(pitch);
  endfunction

endpackage

// File: rtl/note_track_scroller_slot.sv
// note_slot: one falling-note register.
// Ports:
//   pixel_clk, reset : clock, asynchronous active-high reset
//   alloc, lane      : load a new note at TOP_Y in the given lane
//   advance, speed   : move the note down by speed pixels
//   clear            : retire the note as a hit (overrides advance)
//   active, x, y     : registered slot state
//   retire           : combinational, note falls off the bottom this cycle
module note_slot
  import note_track_scroller_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int TOP_Y      = DEF_TOP_Y,
  parameter int BOTTOM_Y   = DEF_BOTTOM_Y
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic [LANE_W-1:0] lane,
  input  logic              advance,
  input  logic [3:0]        speed,
  input  logic              clear,
  output logic              active,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              retire
);

  logic           active_q, active_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [X_W-1:0] y_sum;

  always_comb begin
    // One bit of headroom so the bottom-edge compare sees the true sum.
    y_sum    = {1'b0, y_q} + X_W'(speed);
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    retire   = 1'b0;
    if (clear) begin
      active_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
    end else if (alloc) begin
      active_d = 1'b1;
      x_d      = lane_to_x(lane, LANES, LANE_X0, LANE_PITCH);
      y_d      = Y_W'(TOP_Y);
    end else if (advance && active_q) begin
      if (y_sum >= X_W'(BOTTOM_Y)) begin
        active_d = 1'b0;
        x_d      = '0;
        y_d      = '0;
        retire   = 1'b1;
      end else begin
        y_d = y_sum[Y_W-1:0];
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign active = active_q;
  assign x      = x_q;
  assign y      = y_q;

endmodule

// File: rtl/note_track_scroller.sv
// note_track_scroller: holds MAX_NOTES falling notes and publishes their
// screen origins for the sprite renderers.
// Ports:
//   pixel_clk, reset         : clock, asynchronous active-high reset
//   frame_tick, speed, pause : per-frame advance control
//   note_valid/lane/ready    : new-note handshake (ready from slot state)
//   hit_valid, hit_lane      : player strike
//   hit_ok, hit_bad, miss    : registered one-cycle result pulses
//   slot_active/x/y          : packed per-slot state, slot i in the i-th field
module note_track_scroller
  import note_track_scroller_pkg::*;
#(
  parameter int MAX_NOTES  = 4,
  parameter int LANES      = DEF_LANES,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int TOP_Y      = DEF_TOP_Y,
  parameter int BOTTOM_Y   = DEF_BOTTOM_Y,
  parameter int HIT_LO     = DEF_HIT_LO,
  parameter int HIT_HI     = DEF_HIT_HI
) (
  input  logic                     pixel_clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [3:0]               speed,
  input  logic                     pause,
  input  logic                     note_valid,
  input  logic [LANE_W-1:0]        note_lane,
  output logic                     note_ready,
  input  logic                     hit_valid,
  input  logic [LANE_W-1:0]        hit_lane,
  output logic                     hit_ok,
  output logic                     hit_bad,
  output logic                     miss,
  output logic [MAX_NOTES-1:0]     slot_active,
  output logic [X_W*MAX_NOTES-1:0] slot_x,
  output logic [Y_W*MAX_NOTES-1:0] slot_y
);

  logic [MAX_NOTES-1:0] active;
  logic [MAX_NOTES-1:0] alloc;
  logic [MAX_NOTES-1:0] clear;
  logic [MAX_NOTES-1:0] retire;
  logic [X_W-1:0]       x_arr [MAX_NOTES];
  logic [Y_W-1:0]       y_arr [MAX_NOTES];
  logic                 advance;

  logic                 free_found;
  logic [X_W-1:0]       hit_x;
  logic                 hit_found;
  logic [Y_W-1:0]       best_y;
  logic [MAX_NOTES-1:0] hit_sel;

  logic hit_ok_q, hit_ok_d;
  logic hit_bad_q, hit_bad_d;
  logic miss_q, miss_d;

  assign advance    = frame_tick & ~pause;
  // Registered slot state only, so a slot freed this cycle is reused next cycle.
  assign note_ready = |(~active);

  // Lowest-index free slot takes the new note.
  always_comb begin
    alloc      = '0;
    free_found = 1'b0;
    for (int i = 0; i < MAX_NOTES; i++) begin
      if (!free_found && !active[i]) begin
        alloc[i]   = note_valid;
        free_found = 1'b1;
      end
    end
  end

  // Lanes are matched by x origin, which is unique per lane. Ascending scan
  // with a strict compare keeps the lowest index on equal y.
  always_comb begin
    hit_x     = lane_to_x(hit_lane, LANES, LANE_X0, LANE_PITCH);
    hit_found = 1'b0;
    best_y    = '0;
    hit_sel   = '0;
    for (int i = 0; i < MAX_NOTES; i++) begin
      if (active[i] && (x_arr[i] == hit_x) &&
          (y_arr[i] >= Y_W'(HIT_LO)) && (y_arr[i] <= Y_W'(HIT_HI)) &&
          (!hit_found || (y_arr[i] > best_y))) begin
        hit_found  = 1'b1;
        best_y     = y_arr[i];
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
    clear = hit_valid ? hit_sel : '0;
  end

  for (genvar g = 0; g < MAX_NOTES; g++) begin : g_slot
    note_slot #(
      .LANES      (LANES),
      .LANE_X0    (LANE_X0),
      .LANE_PITCH (LANE_PITCH),
      .TOP_Y      (TOP_Y),
      .BOTTOM_Y   (BOTTOM_Y)
    ) u_slot (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .alloc     (alloc[g]),
      .lane      (note_lane),
      .advance   (advance),
      .speed     (speed),
      .clear     (clear[g]),
      .active    (active[g]),
      .x         (x_arr[g]),
      .y         (y_arr[g]),
      .retire    (retire[g])
    );
    assign slot_x[g*X_W +: X_W] = x_arr[g];
    assign slot_y[g*Y_W +: Y_W] = y_arr[g];
  end

  always_comb begin
    hit_ok_d  = hit_valid & hit_found;
    hit_bad_d = hit_valid & ~hit_found;
    miss_d    = |retire;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      hit_ok_q  <= 1'b0;
      hit_bad_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      hit_ok_q  <= hit_ok_d;
      hit_bad_q <= hit_bad_d;
      miss_q    <= miss_d;
    end
  end

  assign hit_ok      = hit_ok_q;
  assign hit_bad     = hit_bad_q;
  assign miss        = miss_q;
  assign slot_active = active;

endmodule

// File: doc/note_track_scroller.md
Name: note_track_scroller

Overview:
- Upstream position source for the note sprite renderers: holds up to MAX_NOTES falling notes and publishes each slot's screen x/y origin and active flag, which the blob stage consumes.
- Accepts new-note requests over a valid/ready handshake and advances every active note once per frame tick.
- Resolves player hits against a hit window, and retires notes that fall off the bottom as misses.

Parameters:
- MAX_NOTES, 4, number of concurrent note slots (2..8).
- LANES, 5, number of lanes; lane index width is 3.
- LANE_X0, 100, x origin of lane 0 in pixels.
- LANE_PITCH, 80, x spacing between lanes in pixels.
- TOP_Y, 0, initial y of a newly accepted note.
- BOTTOM_Y, 700, a note whose y reaches or exceeds this is retired as a miss.
- HIT_LO, 560, lower bound (inclusive) of the hit window in y.
- HIT_HI, 640, upper bound (inclusive) of the hit window in y.

Ports:
- pixel_clk  in  1  system pixel clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse once per frame, from the vsync edge.
- speed  in  4  pixels advanced per frame tick.
- pause  in  1  when 1, frame_tick is ignored; positions are frozen.
- note_valid  in  1  new-note request.
- note_lane  in  3  lane of the requested note.
- note_ready  out  1  1 when at least one slot is free.
- hit_valid  in  1  one-cycle player strike.
- hit_lane  in  3  lane struck.
- hit_ok  out  1  one-cycle pulse: a note was hit and retired.
- hit_bad  out  1  one-cycle pulse: strike with no note in the window.
- miss  out  1  one-cycle pulse: at least one note retired at BOTTOM_Y this cycle.
- slot_active  out  MAX_NOTES  per-slot active flag.
- slot_x  out  11*MAX_NOTES  packed x origins; slot i occupies bits [11i+10:11i].
- slot_y  out  10*MAX_NOTES  packed y origins; slot i occupies bits [10i+9:10i].

Behaviour:
- Reset:
  - all slots inactive; slot_x and slot_y all 0.
  - note_ready=1; hit_ok, hit_bad and miss all 0.
- note_ready is combinational: OR of ~slot_active, taken from registered state only.
- Accept:
  - occurs on note_valid & note_ready. Takes the lowest-index free slot.
  - Next cycle: active=1, y=TOP_Y, x=LANE_X0+note_lane*LANE_PITCH computed in 11 bits.
  - note_lane>=LANES is accepted and clamped to LANES-1.
- Advance:
  - occurs on frame_tick & ~pause. Every active slot gets y <= y+speed, computed in 11 bits.
  - If the 11-bit sum >= BOTTOM_Y, the slot is cleared instead (active=0, y=0, x=0) and miss pulses next cycle.
  - A slot accepted in the same cycle is not advanced.
- Hit, on hit_valid:
  - Search active slots of hit_lane whose current registered y is within [HIT_LO, HIT_HI].
  - Pick the one with the largest y; ties go to the lowest index.
  - If found: clear that slot and pulse hit_ok next cycle. Otherwise pulse hit_bad next cycle.
  - Exactly one of hit_ok/hit_bad pulses per hit_valid.
- Simultaneous events, all in one cycle:
  - Hit evaluation uses pre-advance y.
  - The hit-selected slot is cleared and not counted as a miss.
  - Remaining slots advance and may miss.
  - A slot freed this cycle is not reallocated until the next cycle, because ready comes from registered state.
- Output timing:
  - Latency 1 cycle from any input event to its outputs.
  - Outputs are registered and change only on accept, advance or retire.
  - The blob stage samples them during active video, so they are stable within a frame except on tick cycles.
- Asynchronous reset mid-frame clears all slots immediately. Pulses are dropped.

Decomposition:
- Shared package holds:
  - lane-index width (3), x width (11), y width (10);
  - LANE_X0, LANE_PITCH, HIT_LO, HIT_HI, BOTTOM_Y defaults;
  - a lane-to-x function.
- One sub-module, note_slot: a single slot register with inputs alloc, lane, advance, speed and clear; outputs active, x, y, and a retire flag.
- The top level instantiates MAX_NOTES note_slot instances and contains the free-slot priority encoder and the hit selector.

Test Plan:
- Reset, then note_valid with lane 2 -> next cycle slot0 active, x=260, y=0; note_ready stays 1.
- Accept 4 notes back-to-back -> slots 0..3 active in order; note_ready=0; a 5th note_valid is held with no change.
- speed=8, 10 frame ticks with one note active -> y=80. Pause asserted across 3 ticks -> y stays 80.
- Note at y=696 with speed=4, then a tick -> slot cleared and miss pulses 1 cycle. A note at y=692 instead -> y=696, no miss.
- Two lane-1 notes at y=570 and y=600, hit_valid lane 1 -> the y=600 slot is cleared, hit_ok=1; the y=570 slot remains. A second hit with the only note at y=500 -> hit_bad=1.
- All slots full; in one cycle hit_valid, frame_tick and note_valid together:
  - hit slot cleared using pre-advance y; others advance; note not accepted that cycle.
  - Note accepted the following cycle into the freed slot.
